// File: rtl/uart_autobaud.sv
// uart_autobaud
//   Measures the host's bit period from a 0x55 sync byte on the raw RX pin
//   and presents it as CLKS_PER_BIT to the downstream program-load receiver.
//   The result is only published once the stop bit has started, so the
//   receiver never mistakes data bit 7 for a start bit.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   rx_i            raw UART RX pin, asynchronous to clk_i
//   start_i         one-cycle re-arm pulse; clears locked_o / err_o
//   clks_per_bit_o  measured clocks per bit, holds the last good value
//   locked_o        a valid measurement has been captured
//   err_o           the last attempt failed
//   busy_o          a measurement is in progress
module uart_autobaud #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DEFAULT_CPB = 16'd868,
    parameter int               IDLE_CLKS   = 32,
    parameter int               MIN_CPB     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             start_i,
    output logic [CNT_W-1:0] clks_per_bit_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int IDLE_W = $clog2(IDLE_CLKS) + 1;
    localparam int TOT_W  = CNT_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MEAS,
        S_STOP,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_next;
    logic               rx_meta, rx_sync, rx_prev;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_next;
    logic [CNT_W-1:0]   seg_cnt, seg_cnt_next;
    logic [CNT_W-1:0]   ref_len, ref_len_next;
    logic [TOT_W-1:0]   total, total_next;
    logic [2:0]         edge_idx, edge_idx_next;
    logic [CNT_W-1:0]   cpb_meas, cpb_meas_next;
    logic [CNT_W-1:0]   cpb_out, cpb_out_next;
    logic               locked, err;

    logic               rise, fall, any_edge, seg_max;
    logic [CNT_W-1:0]   seg_inc, ref_eff, diff, cpb_calc;
    logic [TOT_W-1:0]   total_sum;
    logic [CNT_W:0]     stop_limit;
    logic               tol_ok, pol_ok;

    assign rise     = rx_sync & ~rx_prev;
    assign fall     = ~rx_sync & rx_prev;
    assign any_edge = rise | fall;
    assign seg_max  = (seg_cnt == {CNT_W{1'b1}});
    assign seg_inc  = seg_max ? seg_cnt : seg_cnt + 1'b1;

    // The first measured segment is the start bit; it becomes the reference,
    // so it is compared against itself and always passes.
    assign ref_eff  = (edge_idx == 3'd0) ? seg_cnt : ref_len;
    assign diff     = (seg_cnt >= ref_eff) ? (seg_cnt - ref_eff) : (ref_eff - seg_cnt);
    assign tol_ok   = (diff <= (ref_eff >> 2));
    // Even-numbered edges leave a low segment, odd ones leave a high segment.
    assign pol_ok   = edge_idx[0] ? fall : rise;

    assign total_sum  = total + TOT_W'(seg_cnt);
    // Eight segments summed: divide by eight with round-to-nearest.
    assign cpb_calc   = CNT_W'((total_sum + TOT_W'(4)) >> 3);
    // Bit 7 may stretch up to 1.5 reference bits before the stop edge is late.
    assign stop_limit = {1'b0, ref_len} + (CNT_W+1)'(ref_len >> 1);

    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt;
        seg_cnt_next  = seg_cnt;
        ref_len_next  = ref_len;
        total_next    = total;
        edge_idx_next = edge_idx;
        cpb_meas_next = cpb_meas;
        cpb_out_next  = cpb_out;

        case (state)
            S_IDLE: begin
                if (rx_sync) begin
                    if (idle_cnt == IDLE_W'(IDLE_CLKS - 1)) begin
                        idle_cnt_next = '0;
                        state_next    = S_START;
                    end else begin
                        idle_cnt_next = idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt_next = '0;
                end
            end
            S_START: begin
                if (fall) begin
                    seg_cnt_next  = CNT_W'(1);
                    total_next    = '0;
                    edge_idx_next = '0;
                    state_next    = S_MEAS;
                end
            end
            S_MEAS: begin
                if (any_edge) begin
                    if (!pol_ok || !tol_ok) begin
                        state_next = S_ERR;
                    end else begin
                        if (edge_idx == 3'd0) ref_len_next = seg_cnt;
                        total_next    = total_sum;
                        seg_cnt_next  = CNT_W'(1);
                        edge_idx_next = edge_idx + 3'd1;
                        if (edge_idx == 3'd7) begin
                            cpb_meas_next = cpb_calc;
                            state_next    = S_STOP;
                        end
                    end
                end else if (seg_max) begin
                    // Line stuck: no edge for a full counter range.
                    state_next = S_ERR;
                end else begin
                    seg_cnt_next = seg_inc;
                end
            end
            S_STOP: begin
                if (rise) begin
                    if (cpb_meas < CNT_W'(MIN_CPB)) begin
                        state_next = S_ERR;
                    end else begin
                        cpb_out_next = cpb_meas;
                        state_next   = S_DONE;
                    end
                end else if ({1'b0, seg_cnt} >= stop_limit) begin
                    state_next = S_ERR;
                end else begin
                    seg_cnt_next = seg_inc;
                end
            end
            S_DONE: state_next = S_DONE;
            S_ERR:  state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase

        // Re-arm wins over everything, including a lock in the same cycle.
        if (start_i) begin
            state_next    = S_IDLE;
            idle_cnt_next = '0;
            cpb_out_next  = cpb_out;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= S_IDLE;
            idle_cnt <= '0;
            seg_cnt  <= '0;
            ref_len  <= '0;
            total    <= '0;
            edge_idx <= '0;
            cpb_meas <= '0;
            cpb_out  <= DEFAULT_CPB;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            rx_meta  <= rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            state    <= state_next;
            idle_cnt <= idle_cnt_next;
            seg_cnt  <= seg_cnt_next;
            ref_len  <= ref_len_next;
            total    <= total_next;
            edge_idx <= edge_idx_next;
            cpb_meas <= cpb_meas_next;
            cpb_out  <= cpb_out_next;
            locked   <= (state_next == S_DONE);
            err      <= (state_next == S_ERR);
        end
    end

    assign clks_per_bit_o = cpb_out;
    assign locked_o       = locked;
    assign err_o          = err;
    assign busy_o         = (state == S_START) || (state == S_MEAS) || (state == S_STOP);

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud
//   Self-checking bench for uart_autobaud: directed frame table, hand-written
//   corner sequences, and randomized frames checked against a run-length
//   reference model of the measurement rules.
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cpb;
    logic        locked, err, busy;

    int checks = 0;
    int failures = 0;
    logic [15:0] model_cpb;

    uart_autobaud dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_i          (rx),
        .start_i       (start),
        .clks_per_bit_o(cpb),
        .locked_o      (locked),
        .err_o         (err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  data;
        int          bl[10];
        logic [15:0] exp_cpb;
        logic        exp_lk;
        logic        exp_er;
    } vec_t;

    localparam int NROWS = 10;
    vec_t tbl[NROWS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_row(input int idx, input string n, input logic [7:0] d, input int base,
                           input logic [15:0] c, input logic l, input logic e);
        tbl[idx].name    = n;
        tbl[idx].data    = d;
        for (int i = 0; i < 10; i++) tbl[idx].bl[i] = base;
        tbl[idx].exp_cpb = c;
        tbl[idx].exp_lk  = l;
        tbl[idx].exp_er  = e;
    endtask

    task automatic drive(input logic level, input int n);
        rx = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic rearm();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("rearm_locked", locked, 0);
        chk("rearm_err", err, 0);
        chk("rearm_busy", busy, 0);
    endtask

    // Idle, then one 8N1 frame with per-bit lengths; optional lock-latency check.
    task automatic send(input int bl[10], input logic [7:0] d, input bit lat);
        logic lev;
        drive(1'b1, 40);
        for (int i = 0; i < 10; i++) begin
            lev = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            rx = lev;
            if (i == 9 && lat) begin
                @(posedge clk); @(posedge clk); #1;
                chk("lat_before", locked, 0);
                @(posedge clk); #1;
                chk("lat_at3", locked, 1);
            end
            repeat (bl[i]) @(negedge clk);
        end
        repeat (10) @(negedge clk);
    endtask

    // Reference model: collapse the frame into alternating-level runs, then
    // apply the reference/tolerance/stop/min rules with plain arithmetic.
    function automatic void model(input int bl[10], input logic [7:0] d, input logic [15:0] cur,
                                  output logic [15:0] c, output logic lk, output logic er,
                                  output bit hang);
        int runs[$];
        logic lev, last;
        int rf, sum, dv, res;
        last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lev = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            if (i > 0 && lev == last) runs[runs.size()-1] = runs[runs.size()-1] + bl[i];
            else runs.push_back(bl[i]);
            last = lev;
        end
        c = cur; lk = 1'b0; er = 1'b0; hang = 1'b0;
        rf = runs[0]; sum = 0;
        for (int k = 0; k < 8; k++) begin
            if (k >= runs.size() - 1) begin
                hang = 1'b1;
                return;
            end
            dv = runs[k] - rf;
            if (dv < 0) dv = -dv;
            if (dv > rf / 4) begin
                er = 1'b1;
                return;
            end
            sum += runs[k];
        end
        if (runs[8] > rf + rf / 2) begin
            er = 1'b1;
            return;
        end
        res = (sum + 4) / 8;
        if (res < 4) er = 1'b1;
        else begin
            lk = 1'b1;
            c = 16'(res);
        end
    endfunction

    initial begin
        logic [15:0] m_c;
        logic        m_l, m_e;
        bit          m_h;
        int          bl[10];
        logic [7:0]  d;
        int          base, j;
        bit          seen;

        set_row(0, "0x0F@104",  8'h0F, 104, 16'd868, 1'b0, 1'b1);
        set_row(1, "0x55@52",   8'h55, 52,  16'd52,  1'b1, 1'b0);
        set_row(2, "0x55@104",  8'h55, 104, 16'd104, 1'b1, 1'b0);
        set_row(3, "jitter105", 8'h55, 104, 16'd105, 1'b1, 1'b0);
        tbl[3].bl[0] = 103; tbl[3].bl[1] = 105; tbl[3].bl[2] = 104; tbl[3].bl[3] = 105;
        tbl[3].bl[4] = 104; tbl[3].bl[5] = 105; tbl[3].bl[6] = 105; tbl[3].bl[7] = 105;
        set_row(4, "0x55@8",    8'h55, 8,   16'd8,   1'b1, 1'b0);
        set_row(5, "0x55@3",    8'h55, 3,   16'd8,   1'b0, 1'b1);
        set_row(6, "tol_edge",  8'h55, 16,  16'd17,  1'b1, 1'b0);
        tbl[6].bl[1] = 20;
        set_row(7, "tol_over",  8'h55, 16,  16'd17,  1'b0, 1'b1);
        tbl[7].bl[1] = 21;
        set_row(8, "stop_late", 8'h55, 16,  16'd17,  1'b0, 1'b1);
        tbl[8].bl[8] = 25;
        set_row(9, "stop_lim",  8'h55, 16,  16'd16,  1'b1, 1'b0);
        tbl[9].bl[8] = 24;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cpb", cpb, 868);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Lock at 104, then async reset in the middle of the stop wait
        for (int i = 0; i < 10; i++) bl[i] = 104;
        send(bl, 8'h55, 1'b1);
        chk("pre_cpb", cpb, 104);
        chk("pre_locked", locked, 1);
        $display("frame pre_rst cpb=%0d locked=%0b err=%0b", cpb, locked, err);
        rearm();
        drive(1'b1, 40);
        drive(1'b0, 104);
        for (int i = 0; i < 7; i++) drive(i[0] ? 1'b0 : 1'b1, 104);
        drive(1'b0, 50);
        chk("stop_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cpb", cpb, 868);
        chk("arst_locked", locked, 0);
        chk("arst_err", err, 0);
        chk("arst_busy", busy, 0);
        $display("frame async_rst cpb=%0d locked=%0b err=%0b", cpb, locked, err);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;

        // Directed table
        for (int r = 0; r < NROWS; r++) begin
            rearm();
            send(tbl[r].bl, tbl[r].data, tbl[r].exp_lk && !tbl[r].data[7]);
            chk({tbl[r].name, "_cpb"}, cpb, tbl[r].exp_cpb);
            chk({tbl[r].name, "_locked"}, locked, tbl[r].exp_lk);
            chk({tbl[r].name, "_err"}, err, tbl[r].exp_er);
            chk({tbl[r].name, "_busy"}, busy, 0);
            $display("frame %s cpb=%0d locked=%0b err=%0b", tbl[r].name, cpb, locked, err);
        end
        model_cpb = tbl[NROWS-1].exp_cpb;

        // Short low glitch followed by a long high segment
        rearm();
        drive(1'b1, 40);
        drive(1'b0, 10);
        drive(1'b1, 40);
        drive(1'b0, 1);
        drive(1'b1, 10);
        chk("glitch_err", err, 1);
        chk("glitch_locked", locked, 0);
        chk("glitch_cpb", cpb, model_cpb);
        $display("frame glitch cpb=%0d locked=%0b err=%0b", cpb, locked, err);

        // Re-arm in the middle of a 20-clk frame after the 4th edge
        rearm();
        drive(1'b1, 40);
        drive(1'b0, 20);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 20);
        drive(1'b0, 6);
        chk("mid_busy", busy, 1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("mid_abort_busy", busy, 0);
        drive(1'b0, 13);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 10);
        chk("mid_rej_busy", busy, 0);
        chk("mid_rej_locked", locked, 0);
        chk("mid_rej_err", err, 0);
        $display("frame mid_abort cpb=%0d locked=%0b err=%0b", cpb, locked, err);
        for (int i = 0; i < 10; i++) bl[i] = 16;
        rearm();
        send(bl, 8'h55, 1'b1);
        chk("after_mid_cpb", cpb, 16);
        chk("after_mid_locked", locked, 1);
        $display("frame after_mid cpb=%0d locked=%0b err=%0b", cpb, locked, err);
        model_cpb = 16'd16;

        // Randomized frames against the model
        for (int n = 0; n < 16; n++) begin
            base = $urandom_range(4, 24);
            j = base / 4 + 1;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h55;
            for (int i = 0; i < 9; i++) bl[i] = base - j + $urandom_range(0, 2 * j);
            bl[9] = base;
            model(bl, d, model_cpb, m_c, m_l, m_e, m_h);
            if (m_h) begin
                d = 8'h55;
                model(bl, d, model_cpb, m_c, m_l, m_e, m_h);
            end
            rearm();
            send(bl, d, 1'b0);
            chk("rand_cpb", cpb, m_c);
            chk("rand_locked", locked, m_l);
            chk("rand_err", err, m_e);
            $display("frame rand%0d data=%02h base=%0d cpb=%0d locked=%0b err=%0b",
                     n, d, base, cpb, locked, err);
            model_cpb = m_c;
        end

        // Line stuck low after the start edge: counter must saturate
        rearm();
        drive(1'b1, 40);
        drive(1'b0, 60000);
        chk("stuck_early_err", err, 0);
        chk("stuck_early_busy", busy, 1);
        seen = 1'b0;
        for (int t = 0; t < 10000; t++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stuck_sat_err", seen, 1);
        chk("stuck_cpb", cpb, model_cpb);
        $display("frame stuck cpb=%0d locked=%0b err=%0b", cpb, locked, err);
        rx = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
